// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the instruction/data memory port arbiter: FSM state encoding and
// ownership constants, plus a helper mapping a state to the port that owns the memory.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StBusyDm = 2'd1,
        StBusyIf = 2'd2
    } arb_state_e;

    typedef logic [1:0] owner_t;

    localparam owner_t OWNER_NONE = 2'd0;
    localparam owner_t OWNER_DM   = 2'd1;
    localparam owner_t OWNER_IF   = 2'd2;

    function automatic owner_t state_owner(input arb_state_e state);
        case (state)
            StBusyDm: return OWNER_DM;
            StBusyIf: return OWNER_IF;
            default:  return OWNER_NONE;
        endcase
    endfunction

endpackage

// File: rtl/mem_watchdog.sv
// Busy-cycle counter for an outstanding memory access; expire reports that the count has
// reached TIMEOUT-1, i.e. the current cycle is the last one the memory is allowed to answer in.
module mem_watchdog #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic en,
    output logic expire
);

    localparam int unsigned CntW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT - 1);

    logic [CntW-1:0] cnt_q;

    assign expire = (cnt_q == CntMax);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (en && !expire) begin
            cnt_q <= cnt_q + CntW'(1);
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and the MEM stage, one access
// in flight, data side first; drives pipeline stalls and a sticky no-response watchdog flag.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_rvalid,
    input  logic              dm_read,
    input  logic              dm_write,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_rvalid,
    output logic              stall_if,
    output logic              stall_mem,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_rvalid,
    output logic              timeout_err
);

    arb_state_e state_q, state_d;
    owner_t     owner;
    logic       err_q, err_d;
    logic       dm_any;
    logic       rsp_valid;
    logic       wd_clear, wd_en, wd_expire;

    assign dm_any   = dm_read | dm_write;
    assign owner    = state_owner(state_q);
    assign wd_clear = (state_q == StIdle);
    assign wd_en    = (state_q != StIdle) & ~mem_rvalid;

    mem_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (wd_clear),
        .en     (wd_en),
        .expire (wd_expire)
    );

    always_comb begin
        state_d   = state_q;
        err_d     = err_q;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        rsp_valid = 1'b0;
        unique case (state_q)
            StIdle: begin
                // Data wins: it belongs to the older instruction. Read+write issues as a write.
                if (dm_any) begin
                    mem_req   = 1'b1;
                    mem_we    = dm_write;
                    mem_addr  = dm_addr;
                    mem_wdata = dm_wdata;
                    if (mem_ready) begin
                        state_d = StBusyDm;
                    end
                end else if (if_req) begin
                    mem_req  = 1'b1;
                    mem_addr = if_addr;
                    if (mem_ready) begin
                        state_d = StBusyIf;
                    end
                end
            end
            StBusyDm, StBusyIf: begin
                // Always return to IDLE after a response, so every access takes >= 2 cycles.
                if (mem_rvalid) begin
                    rsp_valid = 1'b1;
                    state_d   = StIdle;
                end else if (wd_expire) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
        end
    end

    // Responses go to whoever owned the access, even if that requester has since let go.
    assign dm_rvalid = rsp_valid & (owner == OWNER_DM);
    assign if_rvalid = rsp_valid & (owner == OWNER_IF);
    assign dm_rdata  = dm_rvalid ? mem_rdata : '0;
    assign if_rdata  = if_rvalid ? mem_rdata : '0;

    assign stall_mem   = dm_any & ~dm_rvalid;
    assign stall_if    = stall_mem | (if_req & ~if_rvalid);
    assign timeout_err = err_q;

endmodule
